// File: rtl/id_ex_alu_stage.sv
// rtl/id_ex_alu_stage.sv - ID/EX pipeline register with ALU-control decode and operand forwarding
module id_ex_alu_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm,
    input  logic              alu_src,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              reg_write,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              out_valid,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic [3:0]        sel,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_write,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic              valid_q;
    logic              reg_write_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] rs_addr_q;
    logic [REG_AW-1:0] rt_addr_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic              alu_src_q;
    logic [3:0]        sel_q;
    logic [CNT_W-1:0]  bubble_q;

    logic [3:0]        sel_dec;
    logic [CNT_W-1:0]  bubble_inc;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    always_comb begin
        sel_dec = SEL_ADD;
        case (alu_op)
            2'b00: sel_dec = SEL_ADD;
            2'b01: sel_dec = SEL_SUB;
            2'b10: begin
                case (funct)
                    FN_ADD:  sel_dec = SEL_ADD;
                    FN_SUB:  sel_dec = SEL_SUB;
                    FN_AND:  sel_dec = SEL_AND;
                    FN_OR:   sel_dec = SEL_OR;
                    FN_SLT:  sel_dec = SEL_SLT;
                    default: sel_dec = SEL_ADD;
                endcase
            end
            default: sel_dec = SEL_ADD;
        endcase
    end

    // Counter holds at all-ones instead of wrapping.
    assign bubble_inc = (bubble_q == CNT_MAX) ? bubble_q : bubble_q + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            alu_src_q   <= 1'b0;
            sel_q       <= SEL_ADD;
            bubble_q    <= '0;
        end else if (flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            bubble_q    <= bubble_inc;
        end else if (stall) begin
            valid_q     <= valid_q;
        end else if (in_valid) begin
            valid_q     <= 1'b1;
            reg_write_q <= reg_write;
            rd_q        <= rd_addr;
            rs_addr_q   <= rs_addr;
            rt_addr_q   <= rt_addr;
            rs_data_q   <= rs_data;
            rt_data_q   <= rt_data;
            imm_q       <= imm;
            alu_src_q   <= alu_src;
            sel_q       <= sel_dec;
        end else begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            bubble_q    <= bubble_inc;
        end
    end

    // Younger EX/MEM result takes precedence; register 0 is never forwarded.
    always_comb begin
        fwd_a = rs_data_q;
        if (exmem_reg_write && (exmem_rd != REG_ZERO) && (exmem_rd == rs_addr_q)) begin
            fwd_a = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != REG_ZERO) && (memwb_rd == rs_addr_q)) begin
            fwd_a = memwb_result;
        end
    end

    always_comb begin
        fwd_b = rt_data_q;
        if (exmem_reg_write && (exmem_rd != REG_ZERO) && (exmem_rd == rt_addr_q)) begin
            fwd_b = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != REG_ZERO) && (memwb_rd == rt_addr_q)) begin
            fwd_b = memwb_result;
        end
    end

    assign in_ready      = ~stall;
    assign out_valid     = valid_q;
    assign out_reg_write = reg_write_q & valid_q;
    assign out_rd        = rd_q;
    assign sel           = sel_q;
    assign op1           = fwd_a;
    assign op2           = alu_src_q ? imm_q : fwd_b;
    assign bubble_cnt    = bubble_q;

endmodule
